restoring_div16: RTL and testbench

RESTORING_DIV16 -- requirements
Module: restoring_div16

---
 rtl/restoring_div16_pkg.sv | 37 +++
 rtl/restoring_div16_if.sv | 29 ++
 rtl/restoring_div16_div_step.sv | 23 ++
 rtl/restoring_div16.sv | 140 ++++++++++++++
 tb/tb_restoring_div16.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/restoring_div16_pkg.sv
// Shared widths, state encoding and small helpers for the 16/8 restoring divider.
// Widths track the wallace_mult8 product so that div and mult can share operand buses.
package restoring_div16_pkg;

    localparam int MULT_PROD_W = 16;
    localparam int DIV_NUM_W   = MULT_PROD_W;
    localparam int DIV_DEN_W   = 8;
    localparam int DIV_REM_W   = DIV_DEN_W + 1;
    localparam int DIV_STEP_W  = 4;

    localparam logic [DIV_STEP_W-1:0] DIV_LAST_STEP = DIV_STEP_W'(DIV_NUM_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef logic [DIV_NUM_W-1:0] num_t;
    typedef logic [DIV_DEN_W-1:0] den_t;

    typedef struct packed {
        num_t quotient;
        den_t remainder;
        logic div_by_zero;
        logic overflow;
    } div_res_t;

    function automatic num_t neg_num(input num_t x);
        return ~x + num_t'(1);
    endfunction

    function automatic den_t neg_den(input den_t x);
        return ~x + den_t'(1);
    endfunction

endpackage

// File: rtl/restoring_div16_if.sv
// Request/result handshake bundle for restoring_div16: one request channel, one result channel.
// master drives requests and consumes results; slave is the divider.
interface restoring_div16_if;
    import restoring_div16_pkg::*;

    logic in_valid;
    logic in_ready;
    num_t dividend;
    den_t divisor;
    logic is_signed;

    logic out_valid;
    logic out_ready;
    num_t quotient;
    den_t remainder;
    logic div_by_zero;
    logic overflow;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/restoring_div16_div_step.sv
// One combinational radix-2 restoring step: shift in the next dividend bit, subtract if it fits.
// No state, no handshake.
module div_step
    import restoring_div16_pkg::*;
(
    input  logic [DIV_REM_W-1:0] rem,
    input  logic                 num_bit,
    input  den_t                 divisor,
    output logic [DIV_REM_W-1:0] rem_next,
    output logic                 q_bit
);

    logic [DIV_REM_W:0]   shifted;
    logic [DIV_REM_W-1:0] diff;

    assign shifted = {rem, num_bit};
    assign q_bit   = (shifted >= {2'b00, divisor});

    // When the subtract happens, shifted < 2*divisor so its top bit is zero and 9 bits suffice.
    assign diff     = shifted[DIV_REM_W-1:0] - {1'b0, divisor};
    assign rem_next = q_bit ? diff : shifted[DIV_REM_W-1:0];

endmodule

// File: rtl/restoring_div16.sv
// 16/8 signed/unsigned restoring divider: result 16 cycles after accept (1 cycle on divide-by-zero).
// Single operation in flight; result held in DONE until out_ready, requests refused outside IDLE.
module restoring_div16
    import restoring_div16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    restoring_div16_if.slave bus
);

    div_state_t            state_q, state_d;
    logic                  accept, finish;

    logic [DIV_STEP_W-1:0] cnt_q;
    logic [DIV_REM_W-1:0]  rem_q, rem_nxt;
    num_t                  qsh_q;
    den_t                  dvs_mag_q;
    den_t                  dvd_lo_q;
    logic                  q_neg_q, r_neg_q, dbz_q, ovf_q;
    logic                  q_bit;

    logic                  dvd_neg, dvs_neg;
    num_t                  dvd_mag;
    den_t                  dvs_mag;
    num_t                  q_mag, q_fix;
    den_t                  r_fix;
    div_res_t              res_q, res_d;

    assign dvd_neg = bus.is_signed & bus.dividend[DIV_NUM_W-1];
    assign dvs_neg = bus.is_signed & bus.divisor[DIV_DEN_W-1];
    assign dvd_mag = dvd_neg ? neg_num(bus.dividend) : bus.dividend;
    assign dvs_mag = dvs_neg ? neg_den(bus.divisor) : bus.divisor;

    assign accept = (state_q == IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dbz_q || (cnt_q == DIV_LAST_STEP)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            qsh_q     <= '0;
            dvs_mag_q <= '0;
            dvd_lo_q  <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            qsh_q     <= dvd_mag;
            dvs_mag_q <= dvs_mag;
            dvd_lo_q  <= bus.dividend[DIV_DEN_W-1:0];
            q_neg_q   <= dvd_neg ^ dvs_neg;
            r_neg_q   <= dvd_neg;
            dbz_q     <= (bus.divisor == '0);
            ovf_q     <= bus.is_signed && (bus.dividend == 16'h8000) && (bus.divisor == 8'hFF);
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_nxt;
            qsh_q <= {qsh_q[DIV_NUM_W-2:0], q_bit};
        end
    end

    div_step u_step (
        .rem      (rem_q),
        .num_bit  (qsh_q[DIV_NUM_W-1]),
        .divisor  (dvs_mag_q),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    // The last step is folded straight into the result register, so sign fix-up sits on that path.
    assign q_mag = {qsh_q[DIV_NUM_W-2:0], q_bit};
    assign q_fix = q_neg_q ? neg_num(q_mag) : q_mag;
    assign r_fix = r_neg_q ? neg_den(rem_nxt[DIV_DEN_W-1:0]) : rem_nxt[DIV_DEN_W-1:0];

    always_comb begin
        res_d = '0;
        if (dbz_q) begin
            res_d.quotient    = '1;
            res_d.remainder   = dvd_lo_q;
            res_d.div_by_zero = 1'b1;
        end else begin
            res_d.quotient  = q_fix;
            res_d.remainder = r_fix;
            res_d.overflow  = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (finish) begin
            res_q <= res_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = res_q.quotient;
    assign bus.remainder   = res_q.remainder;
    assign bus.div_by_zero = res_q.div_by_zero;
    assign bus.overflow    = res_q.overflow;

    a_done_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == DONE && !bus.out_ready) |=> (state_q == DONE && $stable(res_q)));

endmodule

// File: tb/tb_restoring_div16.sv
// Directed table plus corner sequences (backpressure, mid-op reset) and a randomized model check.
module tb_restoring_div16;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic        sgn;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t tbl [16];

    restoring_div16_if bus ();

    restoring_div16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int lat, output bit rdy_bad);
        lat     = 0;
        rdy_bad = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input vec_t v, input string tag);
        chk({tag, ".q"},   32'(bus.quotient),    32'(v.q));
        chk({tag, ".r"},   32'(bus.remainder),   32'(v.r));
        chk({tag, ".dbz"}, 32'(bus.div_by_zero), 32'(v.dbz));
        chk({tag, ".ovf"}, 32'(bus.overflow),    32'(v.ovf));
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        bit rdy_bad;
        chk({tag, ".idle_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.dividend  = v.dvd;
        bus.divisor   = v.dvs;
        bus.is_signed = v.sgn;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(lat, rdy_bad);
        chk({tag, ".lat"},      lat,           v.lat);
        chk({tag, ".busy_rdy"}, 32'(rdy_bad), 32'd0);
        check_result(v, tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, ".vld_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    function automatic vec_t model(input logic [15:0] a, input logic [7:0] b, input logic s);
        vec_t v;
        int   sa, sb, q, r;
        v.dvd = a; v.dvs = b; v.sgn = s;
        v.dbz = 1'b0; v.ovf = 1'b0; v.lat = 16;
        if (b == 8'd0) begin
            v.q = 16'hFFFF; v.r = a[7:0]; v.dbz = 1'b1; v.lat = 1;
        end else begin
            sa = s ? {{16{a[15]}}, a} : {16'd0, a};
            sb = s ? {{24{b[7]}}, b} : {24'd0, b};
            q  = sa / sb;
            r  = sa % sb;
            v.q   = q[15:0];
            v.r   = r[7:0];
            v.ovf = s && (a == 16'h8000) && (b == 8'hFF);
        end
        return v;
    endfunction

    initial begin
        int   lat;
        bit   rdy_bad;
        vec_t v;

        //          dvd       dvs    sgn   q         r      dbz   ovf   lat
        tbl[0]  = '{16'd1000, 8'd7,  1'b0, 16'd142,  8'd6,  1'b0, 1'b0, 16};
        tbl[1]  = '{16'hFFFF, 8'h01, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b0, 16};
        tbl[2]  = '{16'h00FF, 8'hFF, 1'b0, 16'h0001, 8'h00, 1'b0, 1'b0, 16};
        tbl[3]  = '{16'h1234, 8'h00, 1'b0, 16'hFFFF, 8'h34, 1'b1, 1'b0, 1};
        tbl[4]  = '{16'hFF9C, 8'h07, 1'b1, 16'hFFF2, 8'hFE, 1'b0, 1'b0, 16};
        tbl[5]  = '{16'h8000, 8'hFF, 1'b1, 16'h8000, 8'h00, 1'b0, 1'b1, 16};
        tbl[6]  = '{16'h0064, 8'hF9, 1'b1, 16'hFFF2, 8'h02, 1'b0, 1'b0, 16};
        tbl[7]  = '{16'hFF9C, 8'hF9, 1'b1, 16'h000E, 8'hFE, 1'b0, 1'b0, 16};
        tbl[8]  = '{16'hFF9C, 8'h07, 1'b0, 16'h2484, 8'h00, 1'b0, 1'b0, 16};
        tbl[9]  = '{16'h8000, 8'hFF, 1'b0, 16'h0080, 8'h80, 1'b0, 1'b0, 16};
        tbl[10] = '{16'h8000, 8'h01, 1'b1, 16'h8000, 8'h00, 1'b0, 1'b0, 16};
        tbl[11] = '{16'h1234, 8'h00, 1'b1, 16'hFFFF, 8'h34, 1'b1, 1'b0, 1};
        tbl[12] = '{16'h8000, 8'h80, 1'b1, 16'h0100, 8'h00, 1'b0, 1'b0, 16};
        tbl[13] = '{16'h7FFF, 8'h80, 1'b1, 16'hFF01, 8'h7F, 1'b0, 1'b0, 16};
        tbl[14] = '{16'h0005, 8'h0A, 1'b0, 16'h0000, 8'h05, 1'b0, 1'b0, 16};
        tbl[15] = '{16'h0000, 8'h03, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16};

        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready",  32'(bus.in_ready),    32'd1);
        chk("rst.out_valid", 32'(bus.out_valid),   32'd0);
        chk("rst.q",         32'(bus.quotient),    32'd0);
        chk("rst.r",         32'(bus.remainder),   32'd0);
        chk("rst.dbz",       32'(bus.div_by_zero), 32'd0);
        chk("rst.ovf",       32'(bus.overflow),    32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held 5 cycles while a competing request is presented.
        bus.dividend = 16'd1000; bus.divisor = 8'd7; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(lat, rdy_bad);
        chk("bp.lat", lat, 16);
        bus.dividend = 16'h00FF; bus.divisor = 8'hFF; bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp.hold_vld", 32'(bus.out_valid), 32'd1);
            chk("bp.hold_rdy", 32'(bus.in_ready),  32'd0);
            chk("bp.hold_q",   32'(bus.quotient),  32'd142);
            chk("bp.hold_r",   32'(bus.remainder), 32'd6);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp.rel_vld", 32'(bus.out_valid), 32'd0);
        chk("bp.rel_rdy", 32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp.b2b_acc", 32'(bus.in_ready), 32'd0);
        wait_done(lat, rdy_bad);
        chk("bp.b2b_lat", lat, 16);
        check_result(tbl[2], "bp.b2b");
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset pulsed while the divider is at step 7.
        bus.dividend = 16'hFFFF; bus.divisor = 8'h01; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mr.busy_vld", 32'(bus.out_valid), 32'd0);
        chk("mr.busy_rdy", 32'(bus.in_ready),  32'd0);
        rst_n = 1'b0;
        #1;
        chk("mr.vld", 32'(bus.out_valid), 32'd0);
        chk("mr.rdy", 32'(bus.in_ready),  32'd1);
        chk("mr.q",   32'(bus.quotient),  32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mr.idle_vld", 32'(bus.out_valid), 32'd0);
        run_op(tbl[0], "mr.next");

        for (int i = 0; i < 2000; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            logic        s;
            a = 16'($urandom);
            b = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) b = 8'h00;
            if (i % 97 == 0) begin
                a = 16'h8000; b = 8'hFF; s = 1'b1;
            end
            v = model(a, b, s);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
